pcie_ss_ctrl_bridge: RTL and testbench



---
 rtl/ofs_fim_cfg_pkg.sv | 4 +
 rtl/pcie_ss_ctrl_pkg.sv | 20 ++
 rtl/pcie_ss_ctrl_bridge_if.sv | 23 ++
 rtl/pcie_ss_ctrl_timer.sv | 31 +++
 rtl/pcie_ss_ctrl_bridge.sv | 140 ++++++++++++++
 tb/tb_pcie_ss_ctrl_bridge.sv | 298 +++++++++++++++++++++++++++++
 6 files changed

// File: rtl/ofs_fim_cfg_pkg.sv
// FIM platform configuration constants shared by the PCIe subsystem blocks.
package ofs_fim_cfg_pkg;
    localparam int PCIE_LITE_CSR_WIDTH = 20;
endpackage

// File: rtl/pcie_ss_ctrl_pkg.sv
// Shared types for the PCIe SS control bridge: CSR command encoding and FSM states.
package pcie_ss_ctrl_pkg;
    typedef enum logic [1:0] {
        SS_CMD_IDLE    = 2'b00,
        SS_CMD_WRITE   = 2'b01,
        SS_CMD_READ    = 2'b10,
        SS_CMD_ILLEGAL = 2'b11
    } t_ss_ctrl_cmd;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_RDWAIT,
        ST_DONE
    } t_ss_ctrl_state;

    localparam logic [3:0]  SS_CSR_BE_ALL  = 4'hF;
    localparam logic [31:0] SS_ABORT_RDATA = 32'hFFFF_FFFF;
    localparam int          SS_TMO_CNT_W   = 16;
endpackage

// File: rtl/pcie_ss_ctrl_bridge_if.sv
// Avalon-MM request/response bundle between the control bridge (master) and the SS lite CSR (slave).
interface pcie_ss_ctrl_bridge_if #(
    parameter int ADDR_WIDTH = ofs_fim_cfg_pkg::PCIE_LITE_CSR_WIDTH
);
    logic [ADDR_WIDTH-1:0] o_csr_address;
    logic                  o_csr_read;
    logic                  o_csr_write;
    logic [31:0]           o_csr_writedata;
    logic [3:0]            o_csr_byteenable;
    logic                  i_csr_waitrequest;
    logic [31:0]           i_csr_readdata;
    logic                  i_csr_readdatavalid;

    modport master (
        output o_csr_address, o_csr_read, o_csr_write, o_csr_writedata, o_csr_byteenable,
        input  i_csr_waitrequest, i_csr_readdata, i_csr_readdatavalid
    );

    modport slave (
        input  o_csr_address, o_csr_read, o_csr_write, o_csr_writedata, o_csr_byteenable,
        output i_csr_waitrequest, i_csr_readdata, i_csr_readdatavalid
    );
endinterface

// File: rtl/pcie_ss_ctrl_timer.sv
// Bus-wait watchdog for the control bridge; present only with PCIE_SS_CTRL_TIMEOUT_EN.
// Counts busy cycles from request entry, flags expiry combinationally on the last allowed cycle.
`ifdef PCIE_SS_CTRL_TIMEOUT_EN
module pcie_ss_ctrl_timer
    import pcie_ss_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic run,
    output logic expired
);
    localparam logic [SS_TMO_CNT_W-1:0] LAST = SS_TMO_CNT_W'(TIMEOUT_CYCLES - 1);

    logic [SS_TMO_CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (run) begin
            cnt <= cnt + SS_TMO_CNT_W'(1);
        end
    end

    assign expired = run && (cnt == LAST);
endmodule
`endif

// File: rtl/pcie_ss_ctrl_bridge.sv
// Turns level CSR commands into single Avalon-MM accesses; ack 2 cycles after start (+read return), held until cmd=00.
// Backpressure: request held through waitrequest; optional abort with PCIE_SS_CTRL_TIMEOUT_EN.
module pcie_ss_ctrl_bridge
    import pcie_ss_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH     = ofs_fim_cfg_pkg::PCIE_LITE_CSR_WIDTH,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            i_ss_ctrl_cmd,
    input  logic [ADDR_WIDTH-1:0] i_ss_ctrl_addr,
    input  logic [31:0]           i_ss_ctrl_writedata,
    output logic [31:0]           o_ss_readdata,
    output logic                  o_ss_ack,
    output logic                  o_ss_error,
    pcie_ss_ctrl_bridge_if.master csr
);
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("pcie_ss_ctrl_bridge: TIMEOUT_CYCLES out of range 2..65535");
    end

    t_ss_ctrl_state        state, state_nxt;
    t_ss_ctrl_cmd          cmd, cap_cmd;
    logic [ADDR_WIDTH-1:0] cap_addr;
    logic [31:0]           cap_wdata;
    logic                  armed;
    logic                  start;
    logic                  timeout_hit;
    logic                  timeout_abort;

    assign cmd   = t_ss_ctrl_cmd'(i_ss_ctrl_cmd);
    // armed guarantees a level command held across completion or reset is issued only once
    assign start = (state == ST_IDLE) && armed && (cmd != SS_CMD_IDLE);

`ifdef PCIE_SS_CTRL_TIMEOUT_EN
    pcie_ss_ctrl_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (start),
        .run     ((state == ST_REQ) || (state == ST_RDWAIT)),
        .expired (timeout_hit)
    );
`else
    assign timeout_hit = 1'b0;
`endif

    // A bus completion on the expiry cycle wins over the abort
    assign timeout_abort = timeout_hit &&
                           (((state == ST_REQ) && csr.i_csr_waitrequest) ||
                            ((state == ST_RDWAIT) && !csr.i_csr_readdatavalid));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = (cmd == SS_CMD_ILLEGAL) ? ST_DONE : ST_REQ;
                end
            end
            ST_REQ: begin
                if (!csr.i_csr_waitrequest) begin
                    state_nxt = (cap_cmd == SS_CMD_READ) ? ST_RDWAIT : ST_DONE;
                end else if (timeout_hit) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_RDWAIT: begin
                if (csr.i_csr_readdatavalid || timeout_hit) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (cmd == SS_CMD_IDLE) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        csr.o_csr_read       = 1'b0;
        csr.o_csr_write      = 1'b0;
        csr.o_csr_address    = '0;
        csr.o_csr_writedata  = '0;
        csr.o_csr_byteenable = '0;
        o_ss_ack             = 1'b0;
        case (state)
            ST_REQ: begin
                csr.o_csr_read       = (cap_cmd == SS_CMD_READ);
                csr.o_csr_write      = (cap_cmd == SS_CMD_WRITE);
                csr.o_csr_address    = cap_addr;
                csr.o_csr_writedata  = cap_wdata;
                csr.o_csr_byteenable = SS_CSR_BE_ALL;
            end
            ST_DONE: o_ss_ack = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            armed         <= 1'b0;
            cap_cmd       <= SS_CMD_IDLE;
            cap_addr      <= '0;
            cap_wdata     <= '0;
            o_ss_error    <= 1'b0;
            o_ss_readdata <= '0;
        end else begin
            if (start) begin
                armed         <= 1'b0;
                cap_cmd       <= cmd;
                cap_addr      <= i_ss_ctrl_addr;
                cap_wdata     <= i_ss_ctrl_writedata;
                o_ss_error    <= (cmd == SS_CMD_ILLEGAL);
                o_ss_readdata <= '0;
            end else if (cmd == SS_CMD_IDLE) begin
                armed <= 1'b1;
            end
            if ((state == ST_RDWAIT) && csr.i_csr_readdatavalid) begin
                o_ss_readdata <= csr.i_csr_readdata;
            end
            if (timeout_abort) begin
                o_ss_error    <= 1'b1;
                o_ss_readdata <= SS_ABORT_RDATA;
            end
        end
    end
endmodule

// File: tb/tb_pcie_ss_ctrl_bridge.sv
// Randomised bench for pcie_ss_ctrl_bridge against a transaction-level latency/result model.
module tb_pcie_ss_ctrl_bridge;
    localparam int AW   = ofs_fim_cfg_pkg::PCIE_LITE_CSR_WIDTH;
    localparam int TMO  = 16;
    localparam int MAXC = 1100;
`ifdef PCIE_SS_CTRL_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1:0]    ss_cmd;
    logic [AW-1:0] ss_addr;
    logic [31:0]   ss_wdata;
    logic [31:0]   ss_rdata;
    logic          ss_ack;
    logic          ss_err;

    pcie_ss_ctrl_bridge_if #(.ADDR_WIDTH(AW)) csr ();

    pcie_ss_ctrl_bridge #(
        .ADDR_WIDTH     (AW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .i_ss_ctrl_cmd       (ss_cmd),
        .i_ss_ctrl_addr      (ss_addr),
        .i_ss_ctrl_writedata (ss_wdata),
        .o_ss_readdata       (ss_rdata),
        .o_ss_ack            (ss_ack),
        .o_ss_error          (ss_err),
        .csr                 (csr)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        int          lat;
        logic        err;
        logic [31:0] rdata;
        int          wr;
        int          rd;
        int          ack_len;
    } exp_t;

    // Observations from the last transaction
    int            r_lat, r_wr, r_rd, r_both, r_extra, r_ack_len;
    logic          r_err, r_err_hold, r_err_k1, r_req_at_ack;
    logic [31:0]   r_rdata, r_rdata_hold, r_rdata_k1, r_wd;
    logic [AW-1:0] r_addr;
    logic [3:0]    r_be;

    // Busy cycles = cycles spent with a request outstanding or awaiting read data
    function automatic exp_t model(input logic [1:0] c, input int w, input int d,
                                   input logic [31:0] rd, input bit early, input int hold);
        exp_t e;
        int   busy;
        bit   acc;
        e.err = 1'b0; e.rdata = '0; e.wr = 0; e.rd = 0;
        e.ack_len = early ? 1 : 1 + hold;
        if (c == 2'b11) begin
            e.lat = 1; e.err = 1'b1;
        end else begin
            busy  = w + 1 + ((c == 2'b10) ? d + 1 : 0);
            acc   = 1'b1;
            e.lat = 1 + busy;
            if (c == 2'b10) e.rdata = rd;
            if (TMO_EN && busy > TMO) begin
                e.lat = 1 + TMO; e.err = 1'b1; e.rdata = 32'hFFFF_FFFF;
                acc = (w + 1 <= TMO);
            end
            e.wr = (c == 2'b01 && acc) ? 1 : 0;
            e.rd = (c == 2'b10 && acc) ? 1 : 0;
        end
        return e;
    endfunction

    // Issue one command from IDLE, act as the Avalon slave, then release the command.
    task automatic drive_txn(input logic [1:0] c, input logic [AW-1:0] a, input logic [31:0] wd,
                             input int w, input int d, input logic [31:0] rd,
                             input bit early, input int hold);
        int seen = 0;
        int cnt  = 0;
        bit pend = 1'b0;
        r_lat = -1; r_wr = 0; r_rd = 0; r_both = 0; r_extra = 0; r_ack_len = 0;
        r_addr = '0; r_wd = '0; r_be = '0;
        ss_cmd = c; ss_addr = a; ss_wdata = wd;
        for (int k = 1; k <= MAXC && r_lat < 0; k++) begin
            @(negedge clk);
            csr.i_csr_readdatavalid = 1'b0;
            if (k == 1) begin
                ss_addr  = AW'($urandom);
                ss_wdata = $urandom;
                if (early) ss_cmd = 2'b00;
                r_err_k1 = ss_err; r_rdata_k1 = ss_rdata;
            end
            if (csr.o_csr_read && csr.o_csr_write) r_both++;
            if (ss_ack) begin
                r_lat = k; r_err = ss_err; r_rdata = ss_rdata;
                r_req_at_ack = csr.o_csr_read | csr.o_csr_write;
            end else if (csr.o_csr_read || csr.o_csr_write) begin
                r_addr = csr.o_csr_address; r_wd = csr.o_csr_writedata; r_be = csr.o_csr_byteenable;
                if (seen < w) begin
                    csr.i_csr_waitrequest = 1'b1; seen++;
                end else begin
                    csr.i_csr_waitrequest = 1'b0;
                    if (csr.o_csr_write) r_wr++;
                    else begin r_rd++; pend = 1'b1; cnt = d; end
                end
            end else if (pend) begin
                if (cnt == 0) begin
                    csr.i_csr_readdatavalid = 1'b1; csr.i_csr_readdata = rd; pend = 1'b0;
                end else cnt--;
            end
        end
        if (r_lat >= 0) r_ack_len = 1;
        csr.i_csr_waitrequest = 1'b0;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (csr.o_csr_read || csr.o_csr_write) r_extra++;
            if (ss_ack) r_ack_len++;
        end
        ss_cmd = 2'b00;
        for (int h = 0; h < 4; h++) begin
            @(negedge clk);
            csr.i_csr_readdatavalid = 1'b0;
            if (csr.o_csr_read || csr.o_csr_write) r_extra++;
            if (ss_ack) r_ack_len++;
        end
        r_err_hold = ss_err; r_rdata_hold = ss_rdata;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ss_cmd = 2'b01; ss_addr = AW'($urandom); ss_wdata = $urandom;
        csr.i_csr_waitrequest = 1'b0; csr.i_csr_readdatavalid = 1'b0; csr.i_csr_readdata = '0;
        repeat (3) @(negedge clk);
        n_vec++; if (ss_ack !== 1'b0) begin n_bad++; $display("FAIL reset_ack got=%b exp=0", ss_ack); end
        n_vec++; if (ss_err !== 1'b0) begin n_bad++; $display("FAIL reset_err got=%b exp=0", ss_err); end
        n_vec++; if (ss_rdata !== 32'h0) begin n_bad++; $display("FAIL reset_rdata got=%h exp=0", ss_rdata); end
        n_vec++;
        if ({csr.o_csr_read, csr.o_csr_write, csr.o_csr_byteenable} !== 6'h0) begin
            n_bad++; $display("FAIL reset_rw_be got=%b%b%h exp=0", csr.o_csr_read, csr.o_csr_write, csr.o_csr_byteenable);
        end
        n_vec++;
        if ({csr.o_csr_address, csr.o_csr_writedata} !== '0) begin
            n_bad++; $display("FAIL reset_addr_data got=%h/%h exp=0", csr.o_csr_address, csr.o_csr_writedata);
        end
        rst_n = 1'b1;
        r_extra = 0; r_ack_len = 0;
        repeat (8) begin
            @(negedge clk);
            if (csr.o_csr_read || csr.o_csr_write) r_extra++;
            if (ss_ack) r_ack_len++;
        end
        n_vec++; if (r_extra !== 0) begin n_bad++; $display("FAIL reset_held_cmd_req got=%0d exp=0", r_extra); end
        n_vec++; if (r_ack_len !== 0) begin n_bad++; $display("FAIL reset_held_cmd_ack got=%0d exp=0", r_ack_len); end
        ss_cmd = 2'b00;
        @(negedge clk);
    endtask

    task automatic test_write();
        exp_t e = model(2'b01, 0, 0, 32'h0, 1'b0, 2);
        drive_txn(2'b01, AW'(20'h00104), 32'hA5A5_0001, 0, 0, 32'h0, 1'b0, 2);
        n_vec++; if (r_lat !== e.lat) begin n_bad++; $display("FAIL write_lat got=%0d exp=%0d", r_lat, e.lat); end
        n_vec++; if (r_wr !== 1 || r_rd !== 0) begin n_bad++; $display("FAIL write_count got=%0d/%0d exp=1/0", r_wr, r_rd); end
        n_vec++; if (r_addr !== AW'(20'h00104)) begin n_bad++; $display("FAIL write_addr got=%h exp=00104", r_addr); end
        n_vec++; if (r_wd !== 32'hA5A5_0001) begin n_bad++; $display("FAIL write_data got=%h exp=a5a50001", r_wd); end
        n_vec++; if (r_be !== 4'hF) begin n_bad++; $display("FAIL write_be got=%h exp=f", r_be); end
        n_vec++; if (r_err !== e.err) begin n_bad++; $display("FAIL write_err got=%b exp=%b", r_err, e.err); end
        n_vec++; if (r_ack_len !== e.ack_len) begin n_bad++; $display("FAIL write_ack_len got=%0d exp=%0d", r_ack_len, e.ack_len); end
    endtask

    task automatic test_read();
        exp_t e = model(2'b10, 3, 1, 32'h1234_5678, 1'b0, 0);
        drive_txn(2'b10, AW'(20'h00200), 32'h0, 3, 1, 32'h1234_5678, 1'b0, 0);
        n_vec++; if (r_lat !== e.lat) begin n_bad++; $display("FAIL read_lat got=%0d exp=%0d", r_lat, e.lat); end
        n_vec++; if (r_rdata !== e.rdata) begin n_bad++; $display("FAIL read_data got=%h exp=%h", r_rdata, e.rdata); end
        n_vec++; if (r_addr !== AW'(20'h00200)) begin n_bad++; $display("FAIL read_addr got=%h exp=00200", r_addr); end
        n_vec++; if (r_err !== 1'b0 || r_rd !== 1) begin n_bad++; $display("FAIL read_err_cnt got=%b/%0d exp=0/1", r_err, r_rd); end
        n_vec++; if (r_rdata_hold !== e.rdata) begin n_bad++; $display("FAIL read_hold got=%h exp=%h", r_rdata_hold, e.rdata); end
        drive_txn(2'b01, AW'($urandom), $urandom, 0, 0, 32'h0, 1'b0, 0);
        n_vec++; if (r_rdata_k1 !== 32'h0) begin n_bad++; $display("FAIL read_clear_on_start got=%h exp=0", r_rdata_k1); end
    endtask

    task automatic test_handshake();
        drive_txn(2'b01, AW'($urandom), $urandom, 1, 0, 32'h0, 1'b0, 6);
        n_vec++; if (r_extra !== 0) begin n_bad++; $display("FAIL hs_no_reissue got=%0d exp=0", r_extra); end
        n_vec++; if (r_ack_len !== 7) begin n_bad++; $display("FAIL hs_ack_len got=%0d exp=7", r_ack_len); end
        drive_txn(2'b01, AW'($urandom), $urandom, 0, 0, 32'h0, 1'b0, 0);
        n_vec++; if (r_wr !== 1) begin n_bad++; $display("FAIL hs_rearm_write got=%0d exp=1", r_wr); end
        drive_txn(2'b10, AW'($urandom), $urandom, 2, 3, 32'hCAFE_0042, 1'b1, 2);
        n_vec++; if (r_ack_len !== 1) begin n_bad++; $display("FAIL early_ack_len got=%0d exp=1", r_ack_len); end
        n_vec++; if (r_rdata !== 32'hCAFE_0042) begin n_bad++; $display("FAIL early_rdata got=%h exp=cafe0042", r_rdata); end
    endtask

    task automatic test_illegal();
        drive_txn(2'b11, AW'($urandom), $urandom, 0, 0, 32'h0, 1'b0, 1);
        n_vec++; if (r_lat !== 1) begin n_bad++; $display("FAIL illegal_lat got=%0d exp=1", r_lat); end
        n_vec++; if (r_err !== 1'b1) begin n_bad++; $display("FAIL illegal_err got=%b exp=1", r_err); end
        n_vec++; if (r_wr + r_rd + r_extra !== 0) begin n_bad++; $display("FAIL illegal_bus got=%0d exp=0", r_wr + r_rd + r_extra); end
        n_vec++; if (r_err_hold !== 1'b1) begin n_bad++; $display("FAIL illegal_err_hold got=%b exp=1", r_err_hold); end
    endtask

    task automatic test_timeout();
        exp_t e = model(2'b10, 1005, 0, 32'h5555_AAAA, 1'b0, 0);
        drive_txn(2'b10, AW'($urandom), 32'h0, 1005, 0, 32'h5555_AAAA, 1'b0, 0);
        n_vec++; if (r_lat !== e.lat) begin n_bad++; $display("FAIL tmo_lat got=%0d exp=%0d", r_lat, e.lat); end
        n_vec++; if (r_err !== e.err) begin n_bad++; $display("FAIL tmo_err got=%b exp=%b", r_err, e.err); end
        n_vec++; if (r_rdata !== e.rdata) begin n_bad++; $display("FAIL tmo_rdata got=%h exp=%h", r_rdata, e.rdata); end
        n_vec++; if (r_rd !== e.rd) begin n_bad++; $display("FAIL tmo_accepted got=%0d exp=%0d", r_rd, e.rd); end
        n_vec++; if (r_req_at_ack !== 1'b0) begin n_bad++; $display("FAIL tmo_req_dropped got=%b exp=0", r_req_at_ack); end
    endtask

    task automatic test_reset_rdwait();
        exp_t e;
        ss_cmd = 2'b10; ss_addr = AW'(20'h00300); csr.i_csr_waitrequest = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_vec++; if (csr.o_csr_read !== 1'b0 || ss_ack !== 1'b0) begin n_bad++; $display("FAIL rst_rdwait_entry got=%b%b exp=00", csr.o_csr_read, ss_ack); end
        rst_n = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({ss_ack, ss_err, ss_rdata, csr.o_csr_read, csr.o_csr_write} !== '0) begin
            n_bad++; $display("FAIL rst_rdwait_outputs got=%b%b%h%b%b exp=0", ss_ack, ss_err, ss_rdata, csr.o_csr_read, csr.o_csr_write);
        end
        rst_n = 1'b1;
        r_extra = 0;
        repeat (10) begin
            @(negedge clk);
            if (csr.o_csr_read || csr.o_csr_write || ss_ack) r_extra++;
        end
        n_vec++; if (r_extra !== 0) begin n_bad++; $display("FAIL rst_no_reissue got=%0d exp=0", r_extra); end
        ss_cmd = 2'b00;
        @(negedge clk);
        e = model(2'b10, 0, 1, 32'h0BAD_F00D, 1'b0, 0);
        drive_txn(2'b10, AW'($urandom), 32'h0, 0, 1, 32'h0BAD_F00D, 1'b0, 0);
        n_vec++; if (r_rd !== 1 || r_rdata !== e.rdata) begin n_bad++; $display("FAIL rst_new_read got=%0d/%h exp=1/%h", r_rd, r_rdata, e.rdata); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            logic [1:0]    c;
            logic [AW-1:0] a;
            logic [31:0]   wd, rd;
            int            w, d, hold, pick;
            bit            early;
            exp_t          e;
            pick  = $urandom_range(0, 9);
            c     = (pick < 4) ? 2'b01 : (pick < 8) ? 2'b10 : 2'b11;
            a     = AW'($urandom); wd = $urandom; rd = $urandom;
            w     = $urandom_range(0, 4); d = $urandom_range(0, 4);
            hold  = $urandom_range(0, 3); early = 1'($urandom_range(0, 1));
            e     = model(c, w, d, rd, early, hold);
            drive_txn(c, a, wd, w, d, rd, early, hold);
            n_vec++; if (r_lat !== e.lat) begin n_bad++; $display("FAIL rnd%0d_lat got=%0d exp=%0d", i, r_lat, e.lat); end
            n_vec++; if (r_err !== e.err) begin n_bad++; $display("FAIL rnd%0d_err got=%b exp=%b", i, r_err, e.err); end
            n_vec++; if (r_rdata !== e.rdata) begin n_bad++; $display("FAIL rnd%0d_rdata got=%h exp=%h", i, r_rdata, e.rdata); end
            n_vec++;
            if (r_wr !== e.wr || r_rd !== e.rd || r_extra !== 0 || r_both !== 0) begin
                n_bad++; $display("FAIL rnd%0d_bus got=%0d/%0d/%0d/%0d exp=%0d/%0d/0/0", i, r_wr, r_rd, r_extra, r_both, e.wr, e.rd);
            end
            n_vec++; if (r_ack_len !== e.ack_len) begin n_bad++; $display("FAIL rnd%0d_ack_len got=%0d exp=%0d", i, r_ack_len, e.ack_len); end
            n_vec++;
            if (r_err_hold !== e.err || r_rdata_hold !== e.rdata) begin
                n_bad++; $display("FAIL rnd%0d_hold got=%b/%h exp=%b/%h", i, r_err_hold, r_rdata_hold, e.err, e.rdata);
            end
            n_vec++;
            if (r_err_k1 !== (c == 2'b11) || r_rdata_k1 !== 32'h0) begin
                n_bad++; $display("FAIL rnd%0d_start_clear got=%b/%h exp=%b/0", i, r_err_k1, r_rdata_k1, (c == 2'b11));
            end
            if (c != 2'b11) begin
                n_vec++;
                if (r_addr !== a || r_be !== 4'hF || (c == 2'b01 && r_wd !== wd)) begin
                    n_bad++; $display("FAIL rnd%0d_req got=%h/%h/%h exp=%h/f/%h", i, r_addr, r_be, r_wd, a, wd);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_handshake();
        test_illegal();
        test_timeout();
        test_reset_rdwait();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
